// File: rtl/machine_timer_irq_if.sv
// Single-cycle word bus between the load/store path and the machine timer block.
// The master drives requests; the slave answers one cycle later.
interface machine_timer_irq_if;
    logic        valid;
    logic        write;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid,
        output write,
        output addr,
        output wdata,
        input  rdata,
        input  ready
    );

    modport slave (
        input  valid,
        input  write,
        input  addr,
        input  wdata,
        output rdata,
        output ready
    );
endinterface

// File: rtl/machine_timer_irq.sv
// Machine-level interrupt source: mtime/mtimecmp timer, msip software bit and the
// external interrupt synchroniser feeding the CSR unit.
module machine_timer_irq #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clock_enable,
    machine_timer_irq_if.slave   bus,
    input  logic                 ext_irq_in,
    output logic                 irq_external,
    output logic                 irq_timer,
    output logic                 irq_software
);

    localparam logic [15:0] PcntLast = 16'(PRESCALE - 1);

    logic [15:0] pcnt_q, pcnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q;
    logic        irq_timer_q;
    logic        s1_q, ext_q;
    logic        inc;
    logic        wr_req, rd_req;

    assign wr_req = bus.valid & bus.write;
    assign rd_req = bus.valid & ~bus.write;

    always_comb begin
        pcnt_d     = pcnt_q;
        inc        = 1'b0;
        if (clock_enable) begin
            if (pcnt_q == PcntLast) begin
                pcnt_d = '0;
                inc    = 1'b1;
            end else begin
                pcnt_d = pcnt_q + 16'd1;
            end
        end

        mtime_d    = inc ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;

        // A bus write to mtime overrides this cycle's increment; no carry into the other half.
        if (wr_req) begin
            case (bus.addr)
                3'd0:    msip_d                = bus.wdata[0];
                3'd2:    mtimecmp_d[31:0]      = bus.wdata;
                3'd3:    mtimecmp_d[63:32]     = bus.wdata;
                3'd4:    mtime_d               = {mtime_q[63:32], bus.wdata};
                3'd5:    mtime_d               = {bus.wdata, mtime_q[31:0]};
                default: ;
            endcase
        end

        rdata_d = rdata_q;
        if (wr_req) begin
            rdata_d = '0;
        end else if (rd_req) begin
            case (bus.addr)
                3'd0:    rdata_d = {31'b0, msip_q};
                3'd2:    rdata_d = mtimecmp_q[31:0];
                3'd3:    rdata_d = mtimecmp_q[63:32];
                3'd4:    rdata_d = mtime_q[31:0];
                3'd5:    rdata_d = mtime_q[63:32];
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q      <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
            irq_timer_q <= 1'b0;
            s1_q        <= 1'b0;
            ext_q       <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            rdata_q     <= rdata_d;
            ready_q     <= bus.valid;
            irq_timer_q <= (mtime_q >= mtimecmp_q);
            s1_q        <= ext_irq_in;
            ext_q       <= s1_q;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.ready    = ready_q;
    assign irq_timer    = irq_timer_q;
    assign irq_software = msip_q;
    assign irq_external = ext_q;

endmodule

// File: tb/tb_machine_timer_irq.sv
// Directed bench for machine_timer_irq: one DUT with PRESCALE=1, one with PRESCALE=4,
// both driven with identical bus stimulus.
module tb_machine_timer_irq;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic clock_enable = 1'b0;
    logic ext_irq_in = 1'b0;
    logic irq_external1, irq_timer1, irq_software1;
    logic irq_external4, irq_timer4, irq_software4;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd1, rd4;
    logic        rdy1, rdy4;

    machine_timer_irq_if bus1 ();
    machine_timer_irq_if bus4 ();

    machine_timer_irq #(.PRESCALE(1)) dut1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .clock_enable (clock_enable),
        .bus          (bus1),
        .ext_irq_in   (ext_irq_in),
        .irq_external (irq_external1),
        .irq_timer    (irq_timer1),
        .irq_software (irq_software1)
    );

    machine_timer_irq #(.PRESCALE(4)) dut4 (
        .clock        (clock),
        .reset_n      (reset_n),
        .clock_enable (clock_enable),
        .bus          (bus4),
        .ext_irq_in   (ext_irq_in),
        .irq_external (irq_external4),
        .irq_timer    (irq_timer4),
        .irq_software (irq_software4)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [2:0] a, input logic [31:0] d);
        bus1.valid = v; bus1.write = w; bus1.addr = a; bus1.wdata = d;
        bus4.valid = v; bus4.write = w; bus4.addr = a; bus4.wdata = d;
    endtask

    // One request cycle; captures the response registered at the request edge.
    task automatic req(input logic w, input logic [2:0] a, input logic [31:0] d);
        drive(1'b1, w, a, d);
        step(1);
        drive(1'b0, 1'b0, 3'd0, 32'd0);
        rd1 = bus1.rdata; rdy1 = bus1.ready;
        rd4 = bus4.rdata; rdy4 = bus4.ready;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        clock_enable = 1'b0;
        do_reset();
        vectors++;
        if ({irq_timer1, irq_software1, irq_external1, bus1.ready} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %b expected 0000",
                     {irq_timer1, irq_software1, irq_external1, bus1.ready});
        end
        vectors++;
        if (bus1.rdata !== 32'h0) begin
            miscompares++; $display("FAIL reset_rdata got %h expected 00000000", bus1.rdata);
        end
        req(1'b0, 3'd2, 32'h0);
        vectors++;
        if (rdy1 !== 1'b1 || rd1 !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL reset_mtimecmp_lo got %b/%h expected 1/ffffffff", rdy1, rd1);
        end
        req(1'b0, 3'd3, 32'h0);
        vectors++;
        if (rd1 !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL reset_mtimecmp_hi got %h expected ffffffff", rd1);
        end
        req(1'b0, 3'd4, 32'h0);
        vectors++;
        if (rd1 !== 32'h0) begin
            miscompares++; $display("FAIL reset_mtime_lo got %h expected 00000000", rd1);
        end
        step(1);
        vectors++;
        if (irq_timer1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_irq_timer got %b expected 0", irq_timer1);
        end
    endtask

    task automatic test_timer_fire_clear();
        int early;
        early = 0;
        req(1'b1, 3'd2, 32'd10);
        req(1'b1, 3'd3, 32'd0);
        clock_enable = 1'b1;
        // mtime reaches 10 after the 10th enabled edge; irq_timer rises one edge later.
        for (int i = 1; i <= 10; i++) begin
            step(1);
            if (irq_timer1 !== 1'b0) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++; $display("FAIL timer_early got %0d high cycles expected 0", early);
        end
        step(1);
        vectors++;
        if (irq_timer1 !== 1'b1) begin
            miscompares++; $display("FAIL timer_rise got %b expected 1", irq_timer1);
        end
        req(1'b1, 3'd2, 32'd100);
        vectors++;
        if (irq_timer1 !== 1'b1) begin
            miscompares++; $display("FAIL timer_hold_after_write got %b expected 1", irq_timer1);
        end
        step(1);
        vectors++;
        if (irq_timer1 !== 1'b0) begin
            miscompares++; $display("FAIL timer_fall got %b expected 0", irq_timer1);
        end
        clock_enable = 1'b0;
    endtask

    task automatic test_prescale_enable();
        do_reset();
        clock_enable = 1'b1;
        step(16);
        clock_enable = 1'b0;
        req(1'b0, 3'd4, 32'h0);
        vectors++;
        if (rd4 !== 32'd4) begin
            miscompares++; $display("FAIL prescale4_mtime got %0d expected 4", rd4);
        end
        vectors++;
        if (rd1 !== 32'd16) begin
            miscompares++; $display("FAIL prescale1_mtime got %0d expected 16", rd1);
        end
        step(10);
        req(1'b0, 3'd4, 32'h0);
        vectors++;
        if (rd4 !== 32'd4 || rd1 !== 32'd16) begin
            miscompares++; $display("FAIL enable_low_hold got %0d/%0d expected 4/16", rd4, rd1);
        end
    endtask

    task automatic test_wrap_priority();
        req(1'b1, 3'd5, 32'hFFFF_FFFF);
        req(1'b1, 3'd4, 32'hFFFF_FFFE);
        req(1'b0, 3'd5, 32'h0);
        vectors++;
        if (rd1 !== 32'hFFFF_FFFF || rd4 !== 32'hFFFF_FFFF) begin
            miscompares++; $display("FAIL mtime_hi_write got %h/%h expected ffffffff", rd1, rd4);
        end
        clock_enable = 1'b1;
        step(2);
        clock_enable = 1'b0;
        req(1'b0, 3'd4, 32'h0);
        vectors++;
        if (rd1 !== 32'h0) begin
            miscompares++; $display("FAIL wrap_lo got %h expected 00000000", rd1);
        end
        req(1'b0, 3'd5, 32'h0);
        vectors++;
        if (rd1 !== 32'h0) begin
            miscompares++; $display("FAIL wrap_hi got %h expected 00000000", rd1);
        end
        clock_enable = 1'b1;
        req(1'b1, 3'd4, 32'd5);
        req(1'b0, 3'd4, 32'h0);
        clock_enable = 1'b0;
        vectors++;
        if (rd1 !== 32'd5) begin
            miscompares++; $display("FAIL write_beats_inc got %0d expected 5", rd1);
        end
    endtask

    task automatic test_sw_ext();
        logic exp;
        int   bad;
        req(1'b1, 3'd0, 32'h1);
        vectors++;
        if (irq_software1 !== 1'b1 || rd1 !== 32'h0) begin
            miscompares++; $display("FAIL msip_set got %b/%h expected 1/00000000", irq_software1, rd1);
        end
        req(1'b0, 3'd0, 32'h0);
        vectors++;
        if (rd1 !== 32'h1) begin
            miscompares++; $display("FAIL msip_read got %h expected 00000001", rd1);
        end
        req(1'b1, 3'd0, 32'h0);
        vectors++;
        if (irq_software1 !== 1'b0) begin
            miscompares++; $display("FAIL msip_clear got %b expected 0", irq_software1);
        end
        bad = 0;
        ext_irq_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            if (i == 3) ext_irq_in = 1'b0;
            exp = (i >= 2 && i <= 4);
            if (irq_external1 !== exp) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++; $display("FAIL ext_sync got %0d wrong cycles expected 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        req(1'b1, 3'd4, 32'h1234_5678);
        req(1'b1, 3'd5, 32'h9ABC_DEF0);
        drive(1'b1, 1'b0, 3'd4, 32'h0);
        step(1);
        drive(1'b1, 1'b0, 3'd5, 32'h0);
        vectors++;
        if (bus1.ready !== 1'b1 || bus1.rdata !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL b2b_first got %b/%h expected 1/12345678", bus1.ready, bus1.rdata);
        end
        step(1);
        drive(1'b0, 1'b0, 3'd0, 32'h0);
        vectors++;
        if (bus1.ready !== 1'b1 || bus1.rdata !== 32'h9ABC_DEF0) begin
            miscompares++;
            $display("FAIL b2b_second got %b/%h expected 1/9abcdef0", bus1.ready, bus1.rdata);
        end
        step(1);
        vectors++;
        if (bus1.ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle got %b expected 0", bus1.ready);
        end
        req(1'b0, 3'd7, 32'h0);
        vectors++;
        if (rdy1 !== 1'b1 || rd1 !== 32'h0) begin
            miscompares++; $display("FAIL reserved7 got %b/%h expected 1/00000000", rdy1, rd1);
        end
        req(1'b0, 3'd4, 32'h0);
        req(1'b0, 3'd1, 32'h0);
        vectors++;
        if (rd1 !== 32'h0) begin
            miscompares++; $display("FAIL reserved1 got %h expected 00000000", rd1);
        end
        // Reset asserted while a request is in flight: no response.
        drive(1'b1, 1'b0, 3'd4, 32'h0);
        #2 reset_n = 1'b0;
        step(1);
        drive(1'b0, 1'b0, 3'd0, 32'h0);
        vectors++;
        if (bus1.ready !== 1'b0 || bus1.rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_in_flight got %b/%h expected 0/00000000", bus1.ready, bus1.rdata);
        end
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'd0, 32'h0);
        #1;
        test_reset();
        test_timer_fire_clear();
        test_prescale_enable();
        test_wrap_priority();
        test_sw_ext();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
